// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard, forwarding and load-use stall control for the
// pipelined CPU. A shadow pipeline, fed only from ID, records every in-flight
// register writer. Each ID read port is matched against it to choose a
// forwarding source, and a single stall is raised when a read depends on a
// load that cannot be forwarded yet.
module pipe_hazard_ctrl #(
  parameter int  REG_W            = 4,
  parameter int  NUM_RD_PORTS     = 2,
  parameter int  FWD_STAGES       = 3,
  parameter int  LOAD_AVAIL_STAGE = 2,
  parameter int  FLUSH_DEPTH      = 2,
  parameter int  ZERO_REG         = 1,
  parameter int  PERF_W           = 16,
  localparam int SEL_W            = $clog2(FWD_STAGES + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            hlt,
  input  logic                            flush,
  input  logic                            id_valid,
  input  logic                            id_wr_en,
  input  logic [REG_W-1:0]                id_wr_reg,
  input  logic                            id_is_load,
  input  logic [NUM_RD_PORTS-1:0]         id_rd_en,
  input  logic [NUM_RD_PORTS*REG_W-1:0]   id_rd_reg,
  output logic [NUM_RD_PORTS*SEL_W-1:0]   fwd_sel,
  output logic                            stall,
  output logic [PERF_W-1:0]               stall_cnt,
  output logic [PERF_W-1:0]               fwd_cnt
);

  // Shadow entry k-1 describes the instruction currently in stage k
  // (index 0 = EX). Fields are kept in parallel vectors.
  logic [FWD_STAGES-1:0] sh_valid;
  logic [FWD_STAGES-1:0] sh_wr_en;
  logic [FWD_STAGES-1:0] sh_is_load;
  logic [REG_W-1:0]      sh_wr_reg [FWD_STAGES];

  logic [NUM_RD_PORTS-1:0] port_hazard;
  logic                    any_fwd;
  logic                    stage_in_bubble;
  logic [REG_W-1:0]        src;
  logic                    found;

  // Per-port forwarding select (youngest matching writer) and load-use hazard.
  always_comb begin
    fwd_sel     = '0;
    port_hazard = '0;
    src         = '0;
    found       = 1'b0;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      src   = id_rd_reg[p*REG_W +: REG_W];
      found = 1'b0;
      for (int k = 0; k < FWD_STAGES; k++) begin
        if (!found && id_valid && id_rd_en[p] &&
            sh_valid[k] && sh_wr_en[k] && (sh_wr_reg[k] == src) &&
            !((ZERO_REG != 0) && (src == '0))) begin
          found                       = 1'b1;
          fwd_sel[p*SEL_W +: SEL_W]   = SEL_W'(k + 1);
          // Stage numbers below LOAD_AVAIL_STAGE do not yet hold load data.
          port_hazard[p]              = sh_is_load[k] && ((k + 1) < LOAD_AVAIL_STAGE);
        end
      end
    end
  end

  // Stall is suppressed whenever the pipeline is being squashed, frozen or reset.
  always_comb begin
    any_fwd         = |fwd_sel;
    stall           = (|port_hazard) && !flush && !hlt && !rst;
    stage_in_bubble = stall || flush || !id_valid;
  end

  // Shadow pipeline: shift one stage per unfrozen cycle, squash on flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_valid   <= '0;
      sh_wr_en   <= '0;
      sh_is_load <= '0;
      for (int k = 0; k < FWD_STAGES; k++) begin
        sh_wr_reg[k] <= '0;
      end
    end else if (!hlt) begin
      for (int k = 1; k < FWD_STAGES; k++) begin
        if (flush && (k < FLUSH_DEPTH)) begin
          sh_valid[k]   <= 1'b0;
          sh_wr_en[k]   <= 1'b0;
          sh_is_load[k] <= 1'b0;
          sh_wr_reg[k]  <= '0;
        end else begin
          sh_valid[k]   <= sh_valid[k-1];
          sh_wr_en[k]   <= sh_wr_en[k-1];
          sh_is_load[k] <= sh_is_load[k-1];
          sh_wr_reg[k]  <= sh_wr_reg[k-1];
        end
      end
      if (stage_in_bubble) begin
        sh_valid[0]   <= 1'b0;
        sh_wr_en[0]   <= 1'b0;
        sh_is_load[0] <= 1'b0;
        sh_wr_reg[0]  <= '0;
      end else begin
        sh_valid[0]   <= 1'b1;
        sh_wr_en[0]   <= id_wr_en;
        sh_is_load[0] <= id_is_load;
        sh_wr_reg[0]  <= id_wr_reg;
      end
    end
  end

  // Saturating perf counters; a stalled cycle never counts as forwarding.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else if (!hlt) begin
      if (stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + PERF_W'(1);
      end
      if (any_fwd && !stall && (fwd_cnt != '1)) begin
        fwd_cnt <= fwd_cnt + PERF_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Table-driven bench for pipe_hazard_ctrl. Three instances share the stimulus:
// defaults, ZERO_REG=0, and PERF_W=2 (to reach counter saturation quickly).
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic       rst;
    logic       hlt;
    logic       flush;
    logic       v;
    logic       we;
    logic       ld;
    logic [3:0] wr;
    logic [1:0] re;
    logic [3:0] r0;
    logic [3:0] r1;
    logic       st;
    logic [1:0] f0;
    logic [1:0] f1;
    logic [1:0] fz;
  } vec_t;

  typedef struct packed {
    logic        st;
    logic [1:0]  f1;
    logic [1:0]  f0;
    logic [1:0]  fz;
    logic [15:0] sc;
    logic [15:0] fc;
    logic [15:0] fcz;
    logic [1:0]  sc2;
    logic [1:0]  fc2;
  } exp_t;

  localparam int W = $bits(exp_t);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, hlt, flush, id_valid, id_wr_en, id_is_load;
  logic [3:0]  id_wr_reg;
  logic [1:0]  id_rd_en;
  logic [7:0]  id_rd_reg;
  logic [3:0]  fwd_sel, fwd_sel_z0, fwd_sel_p2;
  logic        stall, stall_z0, stall_p2;
  logic [15:0] stall_cnt, fwd_cnt, stall_cnt_z0, fwd_cnt_z0;
  logic [1:0]  stall_cnt_p2, fwd_cnt_p2;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst), .hlt(hlt), .flush(flush), .id_valid(id_valid),
    .id_wr_en(id_wr_en), .id_wr_reg(id_wr_reg), .id_is_load(id_is_load),
    .id_rd_en(id_rd_en), .id_rd_reg(id_rd_reg), .fwd_sel(fwd_sel),
    .stall(stall), .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
  );

  pipe_hazard_ctrl #(.ZERO_REG(0)) dut_z0 (
    .clk(clk), .rst(rst), .hlt(hlt), .flush(flush), .id_valid(id_valid),
    .id_wr_en(id_wr_en), .id_wr_reg(id_wr_reg), .id_is_load(id_is_load),
    .id_rd_en(id_rd_en), .id_rd_reg(id_rd_reg), .fwd_sel(fwd_sel_z0),
    .stall(stall_z0), .stall_cnt(stall_cnt_z0), .fwd_cnt(fwd_cnt_z0)
  );

  pipe_hazard_ctrl #(.PERF_W(2)) dut_p2 (
    .clk(clk), .rst(rst), .hlt(hlt), .flush(flush), .id_valid(id_valid),
    .id_wr_en(id_wr_en), .id_wr_reg(id_wr_reg), .id_is_load(id_is_load),
    .id_rd_en(id_rd_en), .id_rd_reg(id_rd_reg), .fwd_sel(fwd_sel_p2),
    .stall(stall_p2), .stall_cnt(stall_cnt_p2), .fwd_cnt(fwd_cnt_p2)
  );

  // ---------------- vector builders ----------------
  vec_t vecs[$];

  function automatic vec_t idle();
    vec_t t = '0;
    return t;
  endfunction

  function automatic vec_t wr_op(input logic [3:0] r, input logic ld);
    vec_t t = '0;
    t.v  = 1'b1;
    t.we = 1'b1;
    t.wr = r;
    t.ld = ld;
    return t;
  endfunction

  function automatic vec_t rd_op(input logic [1:0] re, input logic [3:0] r0,
                                 input logic [3:0] r1, input logic st,
                                 input logic [1:0] f0, input logic [1:0] f1);
    vec_t t = '0;
    t.v  = 1'b1;
    t.re = re;
    t.r0 = r0;
    t.r1 = r1;
    t.st = st;
    t.f0 = f0;
    t.f1 = f1;
    t.fz = f0;
    return t;
  endfunction

  function automatic int sat2(input int n);
    return (n > 3) ? 3 : n;
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_vec       = 0;
  int miscompares = 0;
  int m_stall     = 0;
  int m_fwd       = 0;
  int m_fwd_z     = 0;

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] req);
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s vec %0d: got %0h expected %0h", nm, idx, act, req);
    end
  endtask

  task automatic drive(input vec_t t);
    rst        = t.rst;
    hlt        = t.hlt;
    flush      = t.flush;
    id_valid   = t.v;
    id_wr_en   = t.we;
    id_wr_reg  = t.wr;
    id_is_load = t.ld;
    id_rd_en   = t.re;
    id_rd_reg  = {t.r1, t.r0};
  endtask

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) vecs.push_back(idle());
  endtask

  // ---------------- test ----------------
  initial begin
    vec_t t;
    exp_t ex;
    logic [3:0] a, b, c, e, h, r;

    a = 4'($urandom_range(1, 15));
    b = 4'($urandom_range(1, 15));
    c = 4'($urandom_range(1, 15));
    e = 4'($urandom_range(1, 15));
    h = 4'($urandom_range(1, 15));

    // Reset state: a reader with an empty shadow sees no forwarding.
    vecs.push_back(rd_op(2'b11, 4'd3, 4'd3, 1'b0, 2'd0, 2'd0));

    // ALU writer followed by four readers: selects walk 1,2,3,0.
    vecs.push_back(wr_op(a, 1'b0));
    vecs.push_back(rd_op(2'b01, a, 4'd0, 1'b0, 2'd1, 2'd0));
    vecs.push_back(rd_op(2'b01, a, 4'd0, 1'b0, 2'd2, 2'd0));
    vecs.push_back(rd_op(2'b01, a, 4'd0, 1'b0, 2'd3, 2'd0));
    vecs.push_back(rd_op(2'b01, a, 4'd0, 1'b0, 2'd0, 2'd0));
    add_idle(3);

    // Load-use on port 1: one stall cycle, then forward from stage 2,
    // and a following reader sees the load in stage 3 (single bubble).
    vecs.push_back(wr_op(b, 1'b1));
    vecs.push_back(rd_op(2'b10, 4'd0, b, 1'b1, 2'd0, 2'd1));
    vecs.push_back(rd_op(2'b10, 4'd0, b, 1'b0, 2'd0, 2'd2));
    vecs.push_back(rd_op(2'b10, 4'd0, b, 1'b0, 2'd0, 2'd3));
    add_idle(3);

    // Writers of the same register in stages 1 and 3: youngest wins.
    vecs.push_back(wr_op(c, 1'b0));
    vecs.push_back(rd_op(2'b00, 4'd0, 4'd0, 1'b0, 2'd0, 2'd0));
    vecs.push_back(wr_op(c, 1'b0));
    vecs.push_back(rd_op(2'b11, c, c, 1'b0, 2'd1, 2'd1));
    add_idle(3);
    // Same, but the stage-1 instruction names the register without writing it.
    vecs.push_back(wr_op(c, 1'b0));
    vecs.push_back(rd_op(2'b00, 4'd0, 4'd0, 1'b0, 2'd0, 2'd0));
    t = rd_op(2'b00, 4'd0, 4'd0, 1'b0, 2'd0, 2'd0);
    t.wr = c;
    vecs.push_back(t);
    vecs.push_back(rd_op(2'b11, c, c, 1'b0, 2'd3, 2'd3));
    add_idle(3);

    // Register 0: never forwarded with ZERO_REG=1, forwarded with ZERO_REG=0.
    vecs.push_back(wr_op(4'd0, 1'b0));
    t = rd_op(2'b01, 4'd0, 4'd0, 1'b0, 2'd0, 2'd0);
    t.fz = 2'd1;
    vecs.push_back(t);
    add_idle(3);

    // Flush clears the incoming instruction and the EX writer moving to MEM.
    vecs.push_back(wr_op(e, 1'b0));
    t = wr_op(e, 1'b0);
    t.flush = 1'b1;
    vecs.push_back(t);
    vecs.push_back(rd_op(2'b01, e, 4'd0, 1'b0, 2'd0, 2'd0));
    // Load in EX with dependent in ID on a flush cycle: no stall.
    vecs.push_back(wr_op(e, 1'b1));
    t = rd_op(2'b01, e, 4'd0, 1'b0, 2'd1, 2'd0);
    t.flush = 1'b1;
    vecs.push_back(t);
    vecs.push_back(rd_op(2'b01, e, 4'd0, 1'b0, 2'd0, 2'd0));
    add_idle(3);

    // Halt with a pending load-use: frozen, no stall, no counting.
    vecs.push_back(wr_op(h, 1'b1));
    for (int i = 0; i < 3; i++) begin
      t = rd_op(2'b10, 4'd0, h, 1'b0, 2'd0, 2'd1);
      t.hlt = 1'b1;
      vecs.push_back(t);
    end
    vecs.push_back(rd_op(2'b10, 4'd0, h, 1'b1, 2'd0, 2'd1));
    // Reset lands on the cycle after the stall; then everything is clear.
    t = rd_op(2'b10, 4'd0, h, 1'b0, 2'd0, 2'd2);
    t.rst = 1'b1;
    vecs.push_back(t);
    vecs.push_back(rd_op(2'b10, 4'd0, h, 1'b0, 2'd0, 2'd0));
    // Reset asserted while the hazard is present suppresses the stall.
    vecs.push_back(wr_op(h, 1'b1));
    t = rd_op(2'b10, 4'd0, h, 1'b0, 2'd0, 2'd1);
    t.rst = 1'b1;
    vecs.push_back(t);
    vecs.push_back(rd_op(2'b10, 4'd0, h, 1'b0, 2'd0, 2'd0));
    add_idle(3);

    // Repeated load-use pairs drive the 2-bit counters into saturation.
    for (int i = 0; i < 4; i++) begin
      r = 4'($urandom_range(1, 15));
      vecs.push_back(wr_op(r, 1'b1));
      vecs.push_back(rd_op(2'b01, r, 4'd0, 1'b1, 2'd1, 2'd0));
      vecs.push_back(rd_op(2'b01, r, 4'd0, 1'b0, 2'd2, 2'd0));
      add_idle(2);
    end

    // Reset sequence.
    drive(idle());
    rst = 1'b1;
    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      t = vecs[i];
      #1;
      drive(t);
      ex.st  = t.st;
      ex.f1  = t.f1;
      ex.f0  = t.f0;
      ex.fz  = t.fz;
      ex.sc  = 16'(m_stall);
      ex.fc  = 16'(m_fwd);
      ex.fcz = 16'(m_fwd_z);
      ex.sc2 = 2'(sat2(m_stall));
      ex.fc2 = 2'(sat2(m_fwd));
      exp_q.push_back(W'(ex));
      @(negedge clk);
      n_vec++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL scoreboard vec %0d: got empty queue expected an entry", i);
      end else begin
        ex = exp_t'(exp_q.pop_front());
        chk("stall",        i, 32'(stall),        32'(ex.st));
        chk("stall_z0",     i, 32'(stall_z0),     32'(ex.st));
        chk("stall_p2",     i, 32'(stall_p2),     32'(ex.st));
        chk("fwd_sel",      i, 32'(fwd_sel),      32'({ex.f1, ex.f0}));
        chk("fwd_sel_z0",   i, 32'(fwd_sel_z0),   32'({ex.f1, ex.fz}));
        chk("fwd_sel_p2",   i, 32'(fwd_sel_p2),   32'({ex.f1, ex.f0}));
        chk("stall_cnt",    i, 32'(stall_cnt),    32'(ex.sc));
        chk("fwd_cnt",      i, 32'(fwd_cnt),      32'(ex.fc));
        chk("stall_cnt_z0", i, 32'(stall_cnt_z0), 32'(ex.sc));
        chk("fwd_cnt_z0",   i, 32'(fwd_cnt_z0),   32'(ex.fcz));
        chk("stall_cnt_p2", i, 32'(stall_cnt_p2), 32'(ex.sc2));
        chk("fwd_cnt_p2",   i, 32'(fwd_cnt_p2),   32'(ex.fc2));
      end
      // Counter model advances at the coming edge.
      if (t.rst) begin
        m_stall = 0;
        m_fwd   = 0;
        m_fwd_z = 0;
      end else if (!t.hlt) begin
        if (t.st) begin
          m_stall++;
        end else begin
          if ((t.f0 != 2'd0) || (t.f1 != 2'd0)) m_fwd++;
          if ((t.fz != 2'd0) || (t.f1 != 2'd0)) m_fwd_z++;
        end
      end
      @(posedge clk);
    end

    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard drain: got %0d leftover expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, miscompares);
    $finish;
  end

endmodule
